// File: rtl/score_digit_formatter.sv
// Converts NUM_CH binary scores to decimal glyph codes, one double-dabble step per cycle per channel.
// Each channel's slice of char_flat changes only on its commit edge; done pulses once per pass.
module score_digit_formatter #(
   parameter int NUM_CH     = 2,
   parameter int VAL_W      = 14,
   parameter int DIGITS     = 4,
   parameter int MAX_VAL    = 9999,
   parameter int BLANK_LEAD = 1,
   parameter int BLANK_CODE = 39
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       refresh,
   input  logic [NUM_CH*VAL_W-1:0]    value_flat,
   output logic [NUM_CH*DIGITS*6-1:0] char_flat,
   output logic [NUM_CH-1:0]          ch_updated,
   output logic                       busy,
   output logic                       done
);
   localparam int SR_W  = 4*DIGITS + VAL_W;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(VAL_W + 1);
   localparam int CW    = DIGITS*6;

   if (longint'(MAX_VAL) >= 10**DIGITS || longint'(MAX_VAL) >= (longint'(1) << VAL_W)) begin : g_bad_max
      $error("MAX_VAL must be below 10**DIGITS and 2**VAL_W");
   end

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   function automatic logic [SR_W-1:0] load_sr(input logic [VAL_W-1:0] v);
      logic [VAL_W-1:0] s;
      s = (v > VAL_W'(MAX_VAL)) ? VAL_W'(MAX_VAL) : v;
      return {{(4*DIGITS){1'b0}}, s};
   endfunction

   // Power-up display reads as a single "0" in the rightmost position.
   function automatic logic [CW-1:0] reset_pat();
      logic [CW-1:0] r;
      r = '0;
      for (int d = 0; d < DIGITS-1; d++)
         r[d*6 +: 6] = (BLANK_LEAD != 0) ? 6'(BLANK_CODE) : 6'd0;
      return r;
   endfunction

   localparam logic [CW-1:0] RST_CH = reset_pat();

   state_t                    state_q;
   logic [CH_W-1:0]           ch_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [SR_W-1:0]           sr_q;
   logic [NUM_CH*VAL_W-1:0]   snap_q;
   logic [NUM_CH*CW-1:0]      char_q;
   logic [NUM_CH-1:0]         upd_q;
   logic                      busy_q;
   logic                      done_q;
   logic                      pending_q;

   logic [SR_W-1:0]           sr_add;
   logic [SR_W-1:0]           sr_d;
   logic [CW-1:0]             fmt_d;
   logic [CH_W-1:0]           nxt_ch;
   logic                      last_ch;
   logic                      seen;
   logic [3:0]                dig;

   always_comb begin
      sr_add = sr_q;
      for (int i = 0; i < DIGITS; i++)
         if (sr_q[VAL_W+4*i +: 4] >= 4'd5)
            sr_add[VAL_W+4*i +: 4] = sr_q[VAL_W+4*i +: 4] + 4'd3;
      sr_d = {sr_add[SR_W-2:0], 1'b0};
   end

   // Digit 0 is the most significant BCD nibble; blanking stops at the first non-zero digit.
   always_comb begin
      fmt_d = '0;
      seen  = 1'b0;
      dig   = '0;
      for (int d = 0; d < DIGITS; d++) begin
         dig = sr_q[VAL_W + 4*(DIGITS-1-d) +: 4];
         if (dig != 4'd0) seen = 1'b1;
         if (BLANK_LEAD != 0 && !seen && d != DIGITS-1)
            fmt_d[d*6 +: 6] = 6'(BLANK_CODE);
         else
            fmt_d[d*6 +: 6] = {2'b00, dig};
      end
   end

   assign nxt_ch  = ch_q + CH_W'(1);
   assign last_ch = (ch_q == CH_W'(NUM_CH-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         cnt_q     <= '0;
         sr_q      <= '0;
         snap_q    <= '0;
         char_q    <= {NUM_CH{RST_CH}};
         upd_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         upd_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (refresh) begin
                  snap_q  <= value_flat;
                  sr_q    <= load_sr(value_flat[VAL_W-1:0]);
                  ch_q    <= '0;
                  cnt_q   <= CNT_W'(VAL_W);
                  busy_q  <= 1'b1;
                  state_q <= CONV;
               end
            end
            CONV: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= COMMIT;
               if (refresh) pending_q <= 1'b1;
            end
            COMMIT: begin
               char_q[ch_q*CW +: CW] <= fmt_d;
               upd_q[ch_q]           <= 1'b1;
               cnt_q                 <= CNT_W'(VAL_W);
               state_q               <= CONV;
               if (!last_ch) begin
                  ch_q <= nxt_ch;
                  sr_q <= load_sr(snap_q[nxt_ch*VAL_W +: VAL_W]);
                  if (refresh) pending_q <= 1'b1;
               end else begin
                  done_q    <= 1'b1;
                  pending_q <= 1'b0;
                  if (pending_q || refresh) begin
                     snap_q <= value_flat;
                     sr_q   <= load_sr(value_flat[VAL_W-1:0]);
                     ch_q   <= '0;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign char_flat  = char_q;
   assign ch_updated = upd_q;
   assign busy       = busy_q;
   assign done       = done_q;
endmodule
